// File: rtl/ssd_display_driver.sv
// Converts a 13-bit binary value to BCD with a sequential double-dabble engine and
// scans the four digits onto an active-low multiplexed seven-segment display.
module ssd_display_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] value,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        busy,
  output logic        done
);

  localparam int             CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]  REF_MAX = CW'(REFRESH_DIV - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_start;
  logic          w_finish;

  logic [12:0]   r_src;
  logic [12:0]   r_shift;
  logic [15:0]   r_work;
  logic [3:0]    r_cnt;
  logic [15:0]   r_bcd;
  logic          r_busy;
  logic          r_done;
  logic [15:0]   w_adj;
  logic [15:0]   w_work_nxt;

  logic [CW-1:0] r_refresh;
  logic [1:0]    r_digit_sel;
  logic [3:0]    w_nib;
  logic [6:0]    w_seg;
  logic          w_blank;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (value != r_src) begin
          w_start     = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt == 4'd12) begin
          w_finish    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Add-3 correction on every nibble >= 5, then shift the next binary bit in.
  always_comb begin
    w_adj = r_work;
    for (int i = 0; i < 4; i++) begin
      if (r_work[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
    end
    w_work_nxt = {w_adj[14:0], r_shift[12]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_src   <= '0;
      r_shift <= '0;
      r_work  <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_start) begin
        r_src   <= value;
        r_shift <= value;
        r_work  <= '0;
        r_cnt   <= '0;
        r_busy  <= 1'b1;
      end else if (r_state == SHIFT) begin
        r_work  <= w_work_nxt;
        r_shift <= {r_shift[11:0], 1'b0};
        r_cnt   <= r_cnt + 4'd1;
        if (w_finish) begin
          r_bcd  <= w_work_nxt;
          r_busy <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_refresh   <= '0;
      r_digit_sel <= '0;
    end else if (r_refresh == REF_MAX) begin
      r_refresh   <= '0;
      r_digit_sel <= r_digit_sel + 2'd1;
    end else begin
      r_refresh   <= r_refresh + CW'(1);
    end
  end

  assign w_nib = r_bcd[4*r_digit_sel +: 4];

  // A digit blanks only when it and every more-significant digit are zero.
  always_comb begin
    w_blank = 1'b0;
    case (r_digit_sel)
      2'd3:    w_blank = BLANK_LZ && (r_bcd[15:12] == 4'd0);
      2'd2:    w_blank = BLANK_LZ && (r_bcd[15:8]  == 8'd0);
      2'd1:    w_blank = BLANK_LZ && (r_bcd[15:4]  == 12'd0);
      default: w_blank = 1'b0;
    endcase
  end

  always_comb begin
    w_seg = 7'b1111111;
    case (w_nib)
      4'd0:    w_seg = 7'b1000000;
      4'd1:    w_seg = 7'b1111001;
      4'd2:    w_seg = 7'b0100100;
      4'd3:    w_seg = 7'b0110000;
      4'd4:    w_seg = 7'b0011001;
      4'd5:    w_seg = 7'b0010010;
      4'd6:    w_seg = 7'b0000010;
      4'd7:    w_seg = 7'b1111000;
      4'd8:    w_seg = 7'b0000000;
      4'd9:    w_seg = 7'b0010000;
      default: w_seg = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      anode <= 4'b1111;
      seg   <= 7'b1111111;
    end else begin
      anode <= ~(4'b0001 << r_digit_sel);
      seg   <= w_blank ? 7'b1111111 : w_seg;
    end
  end

  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_ssd_display_driver.sv
// Randomized bench: a decimal reference model predicts conversions and scan output;
// a scoreboard queue pairs each predicted conversion with the DUT's done pulse.
module tb_ssd_display_driver;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [12:0] value = '0;
  logic [3:0]  anode, anode_nb;
  logic [6:0]  seg, seg_nb;
  logic        busy, busy_nb, done, done_nb;

  always #5 clk = ~clk;

  ssd_display_driver #(.REFRESH_DIV(RD), .BLANK_LZ(1'b1)) u_dut (
    .clk(clk), .rst(rst), .value(value),
    .anode(anode), .seg(seg), .busy(busy), .done(done));

  ssd_display_driver #(.REFRESH_DIV(RD), .BLANK_LZ(1'b0)) u_dut_nb (
    .clk(clk), .rst(rst), .value(value),
    .anode(anode_nb), .seg(seg_nb), .busy(busy_nb), .done(done_nb));

  int checks = 0;
  int errors = 0;

  typedef struct {int val; int at;} exp_t;
  exp_t sb[$];

  int   edge_cnt = 0;
  logic edge_rst = 1'b0;
  int   edge_val = 0;

  int   m_src, m_left, m_pend, m_shown, m_n, m_d;
  bit   m_done;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(int v, int d, bit blank);
    int p = 1;
    for (int k = 0; k < d; k++) p = p * 10;
    if (blank && d > 0 && v < p) return 7'b1111111;
    return seg_of((v / p) % 10);
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  always @(posedge clk) begin
    edge_cnt++;
    edge_rst = rst;
    edge_val = int'(value);
  end

  // Reference model: advance one clock edge per falling edge and check outputs.
  always @(negedge clk) begin
    if (!rst || !edge_rst) begin
      if (!rst) begin
        m_src = 0; m_left = 0; m_shown = 0; m_n = 0;
        sb.delete();
      end
      chk("rst_anode", anode, 4'b1111);
      chk("rst_seg", seg, 7'b1111111);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_anode_nb", anode_nb, 4'b1111);
      chk("rst_seg_nb", seg_nb, 7'b1111111);
    end else begin
      m_d = (m_n / RD) % 4;
      chk("anode", anode, ~(32'd1 << m_d) & 32'hF);
      chk("seg", seg, exp_seg(m_shown, m_d, 1'b1));
      chk("anode_nb", anode_nb, ~(32'd1 << m_d) & 32'hF);
      chk("seg_nb", seg_nb, exp_seg(m_shown, m_d, 1'b0));
      m_n++;
      m_done = 1'b0;
      if (m_left == 0) begin
        if (edge_val != m_src) begin
          m_src  = edge_val;
          m_pend = edge_val;
          m_left = 13;
          sb.push_back('{edge_val, edge_cnt + 13});
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_shown = m_pend;
          m_done  = 1'b1;
        end
      end
      chk("busy", busy, m_left != 0);
      chk("done", done, m_done);
      chk("busy_nb", busy_nb, m_left != 0);
      chk("done_nb", done_nb, m_done);
    end
  end

  // Scoreboard monitor: every done pulse must match the oldest predicted conversion.
  always @(negedge clk) begin
    if (rst) begin
      if (done) begin
        if (sb.size() == 0) begin
          chk("done_unexpected", done, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_edge", edge_cnt, e.at);
          chk("bcd", u_dut.r_bcd, to_bcd(e.val));
        end
      end else if (sb.size() > 0 && edge_cnt > sb[0].at) begin
        chk("done_timeout", done, 1);
        void'(sb.pop_front());
      end
    end
  end

  task automatic set_val(int v);
    @(posedge clk);
    #1 value = 13'(v);
  endtask

  task automatic hold(int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    rst = 1'b0;
    value = '0;
    hold(3);
    #2 rst = 1'b1;
    hold(24);

    set_val(1234); hold(40);
    set_val(8191); hold(40);
    set_val(100);  hold(5);
    set_val(200);  hold(50);
    set_val(7);    hold(40);
    set_val(1000); hold(40);

    set_val(4321); hold(7);
    #2 rst = 1'b0;
    hold(3);
    #2 rst = 1'b1;
    hold(40);

    set_val(0);    hold(40);
    for (int i = 0; i < 25; i++) begin
      set_val(int'($urandom_range(0, 8191)));
      hold(int'($urandom_range(1, 30)));
    end
    hold(40);

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssd_display_driver.md
Name: ssd_display_driver

Overview:
Receiving end of the CPU's 13-bit SSD debug bus. It converts the binary value to four BCD digits with a sequential double-dabble engine. It then drives a multiplexed, active-low, 4-digit seven-segment display, with optional leading-zero blanking. It sits at the board top, between the CPU's SSD output and the display pins.

Parameters:
REFRESH_DIV, 100000, clk cycles each digit stays lit; legal range >= 1.
BLANK_LZ, 1, 1 = blank leading zeros on digits 3..1; 0 = always show all four digits.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
value  input  13  binary value to display (0..8191); may change on any cycle.
anode  output  4  digit enables, active-low; bit 0 = ones digit (rightmost).
seg  output  7  segments, active-low, order {g,f,e,d,c,b,a}.
busy  output  1  high while a conversion is in progress.
done  output  1  one-cycle pulse when new digits are loaded.

Behaviour:
- Reset (rst=0, asynchronous):
  - anode=4'b1111, seg=7'b1111111, busy=0, done=0.
  - src_q=0, bcd_q=16'h0000, refresh counter=0, digit_sel=0, FSM=IDLE.
- Converter FSM, states IDLE and SHIFT:
  - IDLE: if value != src_q at a clock edge, latch value into src_q and the shift register, clear bcd_work, set cnt=0, go to SHIFT, and set busy=1 from that edge. Otherwise stay in IDLE.
  - SHIFT, one iteration per cycle, cnt 0..12:
    - Each nibble of bcd_work that is >= 5 gets +3.
    - Then {bcd_work, shift} shifts left by 1; the binary MSB enters bcd_work bit 0.
  - At the edge with cnt=12: load bcd_q with the final result, pulse done=1 for exactly one cycle, clear busy, go to IDLE.
  - Latency: the latch edge E0 is followed by 13 shift edges, so bcd_q and done update at E13. done is visible in the cycle after E13.
  - value changes during SHIFT are ignored. On return to IDLE the new value differs from src_q, so a fresh conversion starts on the next edge.
  - Back-to-back conversions are therefore separated by one IDLE cycle.
  - No conversion runs when value equals src_q. After reset with value=0, done is never asserted.
  - Arithmetic is 16-bit BCD work plus a 13-bit shift register. 8191 fits in 4 digits, so there is no overflow.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1.
  - On wrap, the counter returns to 0 and digit_sel advances 0→1→2→3→0.
  - With REFRESH_DIV=1, digit_sel advances every cycle.
- Outputs (registered):
  - Each edge, anode gets ~(1<<digit_sel) and seg gets the pattern for bcd_q nibble digit_sel.
  - Outputs therefore lag digit_sel by one cycle.
  - The first edge after reset drives anode=4'b1110.
- Segment patterns {g..a}, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibbles > 9 cannot occur; if they do, drive 1111111.
- Blanking (BLANK_LZ=1):
  - Digit k (k=3..1) shows 1111111 if nibbles 3..k of bcd_q are all zero.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - Internal zeros are never blanked.
- Reset mid-conversion: everything returns to reset values immediately; no done pulse. The conversion restarts after release if value != 0.

Test Plan:
1. rst=0 with value=0, then release; REFRESH_DIV=4, BLANK_LZ=1.
   -> During reset: anode=1111, seg=1111111.
   -> After release: digit 0 shows 1000000 and digits 3..1 show 1111111.
   -> done never pulses; busy stays 0.
2. value=1234 applied at edge E0.
   -> busy rises at E0; done pulses at E13; bcd_q=16'h1234.
   -> Scan: anode 1110/1101/1011/0111 shows seg 0011001/0110000/0100100/1111001, each for 4 cycles.
3. value=8191.
   -> Digits 0..3 show 1111001, 0010000, 1111001, 0000000 (1,9,1,8).
   -> bcd_q=16'h8191 at E13.
4. value=100, then changed to 200 at the 5th SHIFT cycle.
   -> First done shows 100.
   -> One IDLE cycle later a second conversion starts; the second done shows 200.
5. BLANK_LZ=1 with value=7, then value=1000.
   -> For 7: digits 3..1 show 1111111; digit 0 shows 1111000.
   -> For 1000: digits 2..0 show 1000000 (internal zeros not blanked).
   -> With BLANK_LZ=0, value 7 shows 0,0,0,7.
6. rst pulsed low during cnt=6 of the conversion for value=4321.
   -> Outputs go to reset values asynchronously; no done pulse.
   -> After release a full conversion completes with done 13 edges after the latch edge.
